// File: rtl/btn_cond_pkg.sv
// Shared types and 100 MHz defaults for the push-button conditioner.
// Auto-repeat is built only when BTN_COND_AUTOREPEAT_EN is defined.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    REL,
    DELAY,
    REPEAT
  } rep_state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10_000_000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_cond_ch.sv
// One button channel: 2-flop sync, stable-time debounce, edge pulses.
// Repeat FSM present only with BTN_COND_AUTOREPEAT_EN defined.
module btn_cond_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int unsigned CW = cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          hit;
  logic          rise;
  logic          fall;

  assign hit  = (s2 != level) && (cnt == CNT_MAX);
  assign rise = hit && s2;
  assign fall = hit && !s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      press <= rise;
      rel   <= fall;
      if (s2 == level) begin
        cnt <= '0;
      end else if (hit) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BTN_COND_AUTOREPEAT_EN
  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = cnt_w(RMAX);
  localparam logic [RW-1:0] DLY_END = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_END = RW'(REPEAT_PERIOD - 1);

  rep_state_e    st;
  rep_state_e    st_d;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_d;
  logic          rpt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= REL;
      rcnt <= '0;
      rpt  <= 1'b0;
    end else begin
      st   <= st_d;
      rcnt <= rcnt_d;
      rpt  <= rpt_d;
    end
  end

  // Release wins over a due repeat tick.
  always_comb begin
    st_d   = st;
    rcnt_d = rcnt + 1'b1;
    rpt_d  = 1'b0;
    unique case (st)
      REL: begin
        rcnt_d = '0;
        if (rise) st_d = DELAY;
      end
      DELAY: begin
        if (fall) begin
          st_d = REL;
        end else if (rcnt == DLY_END) begin
          st_d   = REPEAT;
          rpt_d  = 1'b1;
          rcnt_d = '0;
        end
      end
      REPEAT: begin
        if (fall) begin
          st_d = REL;
        end else if (rcnt == PER_END) begin
          rpt_d  = 1'b1;
          rcnt_d = '0;
        end
      end
      default: st_d = REL;
    endcase
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner; one independent btn_cond_ch per bit.
// Define BTN_COND_AUTOREPEAT_EN to enable btn_repeat pulses.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_CH          = 5,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_cond_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_in[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i]),
      .rel    (btn_release[i]),
      .rpt    (btn_repeat[i])
    );
  end

endmodule
